serial_tx_arbiter: RTL and testbench
====================================

Name: serial_tx_arbiter

Overview:
- Two-requester scheduler for the team's serial shift-out datapath.
- Accepts parallel words from two independent requesters over valid/ready handshakes.
- Arbitrates round-robin between them and serializes the granted word MSB-first onto a single-bit output stream.
- Sits in front of the chained-DFF serial channel and drives its data input, a per-bit valid, a last-bit marker and a source tag.

Parameters:
- WIDTH, 4, bits per word. Legal range is 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0_valid  input  1  requester 0 has a word to send.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle when valid is also high.
- req1_valid  input  1  requester 1 has a word to send.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle when valid is also high.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit.
- sout_last  output  1  sout is the LSB (final bit) of the current word.
- sout_src  output  1  requester index of the word being shifted.
- busy  output  1  word currently in shift.

Behaviour:
- Reset and reset mid-operation:
  - rst is synchronous, active-high; clock is clk.
  - While rst is high, both ready outputs are 0.
  - On the cycle after rst is sampled high: state=IDLE, priority pointer=0, and sout, sout_valid, sout_last, sout_src, busy and the bit counter are all 0.
  - Reset during SHIFT aborts the word. Remaining bits are dropped and never replayed.
- States and transitions:
  - IDLE to SHIFT on accept.
  - SHIFT stays in SHIFT while cnt<WIDTH-1.
  - At cnt==WIDTH-1, SHIFT goes back to SHIFT on accept (back-to-back), otherwise to IDLE.
- Grant (combinational, from valids and pointer):
  - If both valids are high, the requester named by the pointer is granted.
  - If one valid is high, that requester is granted.
  - If neither is high, there is no grant.
- Ready:
  - reqN_ready = grantN AND (state==IDLE OR (state==SHIFT AND cnt==WIDTH-1)) AND NOT rst.
  - At most one ready is high per cycle.
  - Ready does not depend on the non-granted requester's data.
- Accept:
  - An accept is valid AND ready at a rising edge.
  - On accept from requester i: load the shift register with reqi_data, set sout_src=i, set cnt=0, set pointer = 1-i.
  - The pointer is updated only on accept.
- Timing (registered outputs):
  - For an accept at edge T, sout_valid=1 and busy=1 during cycles T+1..T+WIDTH.
  - sout = data[WIDTH-1-k] in cycle T+1+k.
  - sout_last=1 only in cycle T+WIDTH.
  - Back-to-back words produce no gap: the next word's MSB follows the previous LSB directly.
- Idle outputs: when no word is shifting, sout_valid, sout_last and busy are 0, and sout is driven to 0.
- Requester rules:
  - A requester may drop valid before accept with no effect; no sticky requests are kept.
  - Data must be stable only in the accept cycle. It is captured once and never re-sampled.
- Simultaneous events: a new accept on the last-bit cycle takes priority over returning to IDLE. rst overrides everything.

Test Plan:
1. Single word: WIDTH=4, req0 sends 4'b1011 from IDLE.
   - req0_ready=1 in the accept cycle.
   - Next 4 cycles: sout = 1,0,1,1, sout_valid=1, sout_src=0, sout_last=1 only on the 4th cycle.
   - Then IDLE with sout_valid=0.
2. Back-to-back: req0 holds valid with 4'hA and then 4'h5, req1 idle.
   - Second accept lands on the last-bit cycle.
   - sout streams 1010 then 0101 over 8 consecutive valid cycles with no gap.
3. Contention: both valid continuously, req0=4'hF, req1=4'h0, starting from reset.
   - Grants alternate 0,1,0,1.
   - sout_src toggles every 4 bits and sout is 1111 then 0000, repeating.
   - Ready is never high on both requesters in the same cycle.
4. Reset mid-frame: accept 4'b1100, assert rst in bit-cycle 2 for one cycle.
   - All outputs are 0 the next cycle and the remaining bits are lost.
   - The pointer returns to 0, so with both valid, req0 is granted first.
5. Withdrawn request: req1_valid pulses while a word is mid-shift (cnt<WIDTH-1), then drops.
   - req1_ready stays 0 and no word from req1 is ever emitted.
6. WIDTH=8: req1 sends 8'h81.
   - Output is 1,0,0,0,0,0,0,1 over 8 cycles, with sout_last on the 8th and sout_src=1 throughout.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// Round-robin scheduler for two requesters feeding the serial channel; words are shifted MSB-first.
// Bits appear in the WIDTH cycles after accept; a new word can be taken on the last-bit cycle, so there is no gap.
module serial_tx_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             sout_src,
  output logic             busy
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_shift;
  logic               r_src;

  logic w_last;
  logic w_slot;
  logic w_grant0;
  logic w_grant1;
  logic w_acc0;
  logic w_acc1;
  logic w_acc;

  assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_slot   = (r_state == IDLE) || w_last;

  // On contention the pointer names the winner; a lone requester always wins.
  assign w_grant0 = req0_valid && (!req1_valid || !r_ptr);
  assign w_grant1 = req1_valid && (!req0_valid ||  r_ptr);

  assign req0_ready = w_grant0 && w_slot && !rst;
  assign req1_ready = w_grant1 && w_slot && !rst;

  assign w_acc0 = req0_valid && req0_ready;
  assign w_acc1 = req1_valid && req1_ready;
  assign w_acc  = w_acc0 || w_acc1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = SHIFT;
      SHIFT:   if (w_last && !w_acc) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_src   <= 1'b0;
    end else if (w_acc) begin
      r_shift <= w_acc1 ? req1_data : req0_data;
      r_src   <= w_acc1;
      r_cnt   <= '0;
      r_ptr   <= !w_acc1;
    end else if (r_state == SHIFT) begin
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign sout_valid = (r_state == SHIFT);
  assign busy       = (r_state == SHIFT);
  assign sout       = (r_state == SHIFT) && r_shift[WIDTH-1];
  assign sout_last  = w_last;
  assign sout_src   = r_src;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter at WIDTH=4 and WIDTH=8: grant table plus scoreboarded bit streams.
module tb_serial_tx_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, v1, r0, r1, so, sv, sl, ss, sb;
  logic [3:0] d0, d1;
  logic       v0b, v1b, r0b, r1b, sob, svb, slb, ssb, sbb;
  logic [7:0] d0b, d1b;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  typedef struct packed {logic b; logic last; logic src;} bit_t;
  bit_t q4[$];
  bit_t q8[$];

  typedef struct {logic ptr; logic v0; logic v1; logic r0; logic r1;} vec_t;
  vec_t tbl[8];

  serial_tx_arbiter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .sout(so), .sout_valid(sv), .sout_last(sl), .sout_src(ss), .busy(sb)
  );

  serial_tx_arbiter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(v0b), .req0_data(d0b), .req0_ready(r0b),
    .req1_valid(v1b), .req1_data(d1b), .req1_ready(r1b),
    .sout(sob), .sout_valid(svb), .sout_last(slb), .sout_src(ssb), .busy(sbb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [3:0] d, input logic src);
    bit_t e;
    for (int k = 0; k < 4; k++) begin
      e.b = d[3-k]; e.last = (k == 3); e.src = src;
      q4.push_back(e);
    end
  endtask

  task automatic push8(input logic [7:0] d, input logic src);
    bit_t e;
    for (int k = 0; k < 8; k++) begin
      e.b = d[7-k]; e.last = (k == 7); e.src = src;
      q8.push_back(e);
    end
  endtask

  task automatic run_table(input logic p);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].ptr == p) begin
        v0 = tbl[i].v0; v1 = tbl[i].v1;
        d0 = 4'($urandom); d1 = 4'($urandom);
        @(negedge clk);
        chk($sformatf("tbl%0d_r0", i), r0, tbl[i].r0);
        chk($sformatf("tbl%0d_r1", i), r1, tbl[i].r1);
        v0 = 1'b0; v1 = 1'b0;
        tick();
      end
    end
  endtask

  // Scoreboard: every valid bit must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      bit_t e;
      if (sv) begin
        chk("w4_bit_expected", 32'(q4.size() > 0), 1);
        if (q4.size() > 0) begin
          e = q4.pop_front();
          chk("w4_sout", so, e.b);
          chk("w4_last", sl, e.last);
          chk("w4_src", ss, e.src);
        end
      end else begin
        chk("w4_idle_sout", so, 0);
      end
      if (svb) begin
        chk("w8_bit_expected", 32'(q8.size() > 0), 1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          chk("w8_sout", sob, e.b);
          chk("w8_last", slb, e.last);
          chk("w8_src", ssb, e.src);
        end
      end
    end
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    v0 = 1'b1; v1 = 1'b1; d0 = 4'h3; d1 = 4'hC;
    v0b = 1'b1; v1b = 1'b0; d0b = 8'h00; d1b = 8'h00;
    repeat (2) tick();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_r0", r0, 0);
    chk("rst_r1", r1, 0);
    chk("rst_r0b", r0b, 0);
    chk("rst_sout", so, 0);
    chk("rst_valid", sv, 0);
    chk("rst_last", sl, 0);
    chk("rst_src", ss, 0);
    chk("rst_busy", sb, 0);
    v0 = 1'b0; v1 = 1'b0; v0b = 1'b0;
    rst = 1'b0;
    tick();

    run_table(1'b0);

    // Single word from IDLE
    v0 = 1'b1; d0 = 4'b1011;
    @(negedge clk);
    chk("t1_r0", r0, 1);
    chk("t1_r1", r1, 0);
    push4(4'b1011, 1'b0);
    tick();
    v0 = 1'b0; d0 = 4'h0;
    repeat (4) tick();
    @(negedge clk);
    chk("t1_idle_valid", sv, 0);
    chk("t1_idle_busy", sb, 0);
    chk("t1_idle_last", sl, 0);
    tick();

    run_table(1'b1);

    // Back-to-back on req0: second accept on the last-bit cycle
    v0 = 1'b1; d0 = 4'hA;
    @(negedge clk);
    chk("t2_r0_first", r0, 1);
    push4(4'hA, 1'b0);
    tick();
    d0 = 4'h5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t2_valid%0d", k), sv, 1);
      chk($sformatf("t2_busy%0d", k), sb, 1);
      if (k < 4) chk($sformatf("t2_r0_%0d", k), r0, (k == 3));
      if (k == 3) push4(4'h5, 1'b0);
      tick();
      if (k == 3) v0 = 1'b0;
    end
    @(negedge clk);
    chk("t2_idle_valid", sv, 0);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Contention: grants alternate starting with req0
    v0 = 1'b1; v1 = 1'b1; d0 = 4'hF; d1 = 4'h0;
    for (int c = 0; c <= 16; c++) begin
      logic acc, odd;
      @(negedge clk);
      acc = (c % 4 == 0) && (c <= 12);
      odd = ((c / 4) % 2) == 1;
      chk($sformatf("t3_r0_c%0d", c), r0, acc && !odd);
      chk($sformatf("t3_r1_c%0d", c), r1, acc && odd);
      chk($sformatf("t3_onehot_c%0d", c), r0 && r1, 0);
      if (acc) push4(odd ? 4'h0 : 4'hF, odd);
      tick();
      if (c == 12) begin v0 = 1'b0; v1 = 1'b0; end
    end
    @(negedge clk);
    chk("t3_idle_valid", sv, 0);
    tick();

    // Reset in the second bit cycle drops the rest of the word
    v0 = 1'b1; d0 = 4'b1100;
    @(negedge clk);
    chk("t4_r0", r0, 1);
    q4.push_back('{b: 1'b1, last: 1'b0, src: 1'b0});
    q4.push_back('{b: 1'b1, last: 1'b0, src: 1'b0});
    tick();
    v0 = 1'b0;
    tick();
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 4'h3; d1 = 4'hA;
    @(negedge clk);
    chk("t4_rst_r0", r0, 0);
    chk("t4_rst_r1", r1, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_sout", so, 0);
    chk("t4_valid", sv, 0);
    chk("t4_last", sl, 0);
    chk("t4_src", ss, 0);
    chk("t4_busy", sb, 0);
    chk("t4_ptr_r0", r0, 1);
    chk("t4_ptr_r1", r1, 0);
    push4(4'h3, 1'b0);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("t4_idle_valid", sv, 0);
    tick();

    // req1 pulses mid-shift and withdraws
    v0 = 1'b1; d0 = 4'h6;
    @(negedge clk);
    chk("t5_r0", r0, 1);
    push4(4'h6, 1'b0);
    tick();
    v0 = 1'b0; v1 = 1'b1; d1 = 4'h9;
    @(negedge clk);
    chk("t5_r1_cnt0", r1, 0);
    tick();
    @(negedge clk);
    chk("t5_r1_cnt1", r1, 0);
    tick();
    v1 = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_idle_valid", sv, 0);
    tick();

    // WIDTH=8 word from req1
    v1b = 1'b1; d1b = 8'h81;
    @(negedge clk);
    chk("t6_r1b", r1b, 1);
    chk("t6_r0b", r0b, 0);
    push8(8'h81, 1'b1);
    tick();
    v1b = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("t6_idle_valid", svb, 0);
    chk("t6_idle_busy", sbb, 0);
    tick();

    chk("q4_drained", 32'(q4.size()), 0);
    chk("q8_drained", 32'(q8.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
